i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 24: sample width in bits; legal range 8..32.
REQ-002 Parameter SLOT_WIDTH, default 32: expected BCLK periods per channel slot; legal range DATA_WIDTH..64.
REQ-003 Parameter MODE, default 0: 0 = Philips I2S (MSB one BCLK after the LRCLK transition); 1 = left-justified (MSB in the transition cycle).
REQ-004 Port BCLK, input, 1 bit: bit clock from the codec; the only clock; all logic rising-edge.
REQ-005 Port RST, input, 1 bit: asynchronous active-high reset.
REQ-006 Port LRCLK, input, 1 bit: word select; low = left slot, high = right slot.
REQ-007 Port ADCDAT, input, 1 bit: serial ADC data, MSB first.
REQ-008 Port left, output, signed DATA_WIDTH: last completed left sample.
REQ-009 Port right, output, signed DATA_WIDTH: last completed right sample.
REQ-010 Port left_valid, output, 1 bit: one-cycle pulse when left updates.
REQ-011 Port right_valid, output, 1 bit: one-cycle pulse when right updates.

Function
REQ-012 LRCLK and ADCDAT shall be sampled on every BCLK rising edge; L[k], D[k] denote the values sampled at edge k.
REQ-013 Effective word select ws[k] shall be L[k] for MODE=1 and L[k-1] for MODE=0.
REQ-014 A slot boundary shall occur at edge k when ws[k] != ws[k-1]; D[k] is the MSB of the new slot.
REQ-015 Within a slot, the first DATA_WIDTH bits shall be shifted MSB-first into an accumulator; later bits shall be ignored.
REQ-016 A saturating bit counter shall count the bits of the current slot, restarting at 1 on the boundary edge and holding at 127.
REQ-017 At a boundary, the finished slot's word shall be registered into left (ws[k-1]=0) or right (ws[k-1]=1), with the matching valid pulse high for exactly the cycle after edge k.
REQ-018 Short slot (count < DATA_WIDTH): the received bits shall be left-aligned, with zeros in the missing LSBs.
REQ-019 Long slot (count > DATA_WIDTH): the output shall be the first DATA_WIDTH bits, with no error and no wrap.
REQ-020 The first boundary after reset shall only arm the receiver; its partial slot shall be discarded, with no output change and no valid pulse.
REQ-021 left_valid and right_valid shall never be high in the same cycle.
REQ-022 left and right shall hold their values between updates.
REQ-023 Latency shall be one BCLK from the boundary edge to the registered output and valid pulse.

Reset
REQ-024 On RST high, left, right, left_valid, right_valid, the accumulator, the counter, the LRCLK history registers and the arm flag shall clear to 0 immediately, independent of BCLK.
REQ-025 When RST deasserts mid-slot, the receiver shall restart at the arm step (REQ-020); the interrupted slot shall never be output.

Configuration
REQ-026 With macro I2S_RX_SLOT_CHECK_EN defined, output port slot_err (1 bit) shall exist and pulse with the valid pulse when the finished slot count != SLOT_WIDTH; slot_err shall reset to 0.
REQ-027 With I2S_RX_SLOT_CHECK_EN undefined, the slot_err port and its logic shall be absent; all other behaviour shall be identical.

Verification
REQ-028 Arm and basic capture: MODE=0, DATA_WIDTH=24, SLOT_WIDTH=32; one discarded partial slot, then left=0x123456 and right=0xABCDEF (zero-padded to 32) -> no pulse at the first boundary; left=0x123456 with left_valid; then right=0xABCDEF (sign-negative) with right_valid, one cycle after each boundary.
REQ-029 Mode alignment: same bit stream with MODE=1 and the MSB placed in the transition cycle -> identical outputs; with MODE=0 fed that LJ stream -> the word is shifted by one bit (0x2468AC for 0x123456).
REQ-030 Short slot: DATA_WIDTH=24; a 16-bit slot carrying 0x8001 -> left=0x800100; with the macro defined, slot_err=1.
REQ-031 Long slot: DATA_WIDTH=16, SLOT_WIDTH=64; 64 bits with first 16 = 0x7FFF -> output 0x7FFF; slot_err=0.
REQ-032 Reset mid-operation: assert RST during bit 10 of a left slot, release, continue the stream -> outputs 0 during reset; the next boundary only arms; the first valid pulse follows the next complete slot.
REQ-033 Slot check: SLOT_WIDTH=32; slots of 32, 31, 33 BCLKs -> slot_err 0, 1, 1 coincident with the valid pulses.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver, clocked entirely by BCLK.
// Captures the first DATA_WIDTH bits of each channel slot MSB-first and
// presents the finished word one BCLK after the slot boundary, together
// with a one-cycle left_valid or right_valid pulse.
// Optional feature: define I2S_RX_SLOT_CHECK_EN to add the slot_err output,
// which flags finished slots whose BCLK count differs from SLOT_WIDTH.
// Output handshake: left_valid/right_valid are single-cycle strobes with no
// ready/back-pressure; left/right are valid on the strobe and hold until the
// next strobe of the same channel.
module i2s_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int MODE       = 0
) (
    input  logic                         BCLK,
    input  logic                         RST,
    input  logic                         LRCLK,
    input  logic                         ADCDAT,
    output logic signed [DATA_WIDTH-1:0] left,
    output logic signed [DATA_WIDTH-1:0] right,
    output logic                         left_valid,
    output logic                         right_valid
`ifdef I2S_RX_SLOT_CHECK_EN
    ,
    output logic                         slot_err
`endif
);

    // Reject illegal widths at elaboration time.
    if (DATA_WIDTH < 8 || DATA_WIDTH > 32 || SLOT_WIDTH < DATA_WIDTH || SLOT_WIDTH > 64) begin : g_param_check
        $error("i2s_rx: illegal DATA_WIDTH/SLOT_WIDTH combination");
    end

    logic                         r_lr_d1;   // LRCLK sampled at the previous edge
    logic                         r_ws_d;    // effective word select of the previous edge
    logic                         r_armed;   // set once the first boundary after reset is seen
    logic [6:0]                   r_cnt;     // bits received in the current slot, saturating
    logic [DATA_WIDTH-1:0]        r_acc;     // current slot word, left-aligned
    logic signed [DATA_WIDTH-1:0] r_left;
    logic signed [DATA_WIDTH-1:0] r_right;
    logic                         r_left_valid;
    logic                         r_right_valid;

    logic                         w_ws;
    logic                         w_boundary;
    logic [DATA_WIDTH-1:0]        w_acc_next;

    // Philips mode delays word select by one BCLK so the MSB lands one bit
    // after the LRCLK transition; left-justified mode uses LRCLK directly.
    assign w_ws       = (MODE == 1) ? LRCLK : r_lr_d1;
    assign w_boundary = w_ws ^ r_ws_d;

    // Next accumulator: a boundary starts a fresh word with D[k] as MSB; otherwise
    // bit number r_cnt lands at its MSB-first position, and bits past DATA_WIDTH
    // are dropped. Unreceived LSBs stay zero, which left-aligns short slots.
    always_comb begin
        w_acc_next = r_acc;
        if (w_boundary) begin
            w_acc_next                 = '0;
            w_acc_next[DATA_WIDTH-1]   = ADCDAT;
        end else if (r_cnt < 7'(DATA_WIDTH)) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i == DATA_WIDTH - 1 - int'(r_cnt)) begin
                    w_acc_next[i] = ADCDAT;
                end
            end
        end
    end

    // Slot tracking, word capture and output registers with valid strobes.
    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            r_lr_d1       <= 1'b0;
            r_ws_d        <= 1'b0;
            r_armed       <= 1'b0;
            r_cnt         <= 7'd0;
            r_acc         <= '0;
            r_left        <= '0;
            r_right       <= '0;
            r_left_valid  <= 1'b0;
            r_right_valid <= 1'b0;
        end else begin
            r_lr_d1       <= LRCLK;
            r_ws_d        <= w_ws;
            r_acc         <= w_acc_next;
            r_left_valid  <= 1'b0;
            r_right_valid <= 1'b0;
            if (w_boundary) begin
                r_cnt   <= 7'd1;
                r_armed <= 1'b1;
                // The slot ending before the first boundary is partial: drop it.
                if (r_armed) begin
                    if (r_ws_d) begin
                        r_right       <= r_acc;
                        r_right_valid <= 1'b1;
                    end else begin
                        r_left        <= r_acc;
                        r_left_valid  <= 1'b1;
                    end
                end
            end else if (r_cnt != 7'd127) begin
                r_cnt <= r_cnt + 7'd1;
            end
        end
    end

`ifdef I2S_RX_SLOT_CHECK_EN
    logic r_slot_err;

    // Flag a finished slot whose bit count is not the nominal slot width.
    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            r_slot_err <= 1'b0;
        end else begin
            r_slot_err <= w_boundary && r_armed && (r_cnt != 7'(SLOT_WIDTH));
        end
    end

    assign slot_err = r_slot_err;
`endif

    assign left        = r_left;
    assign right       = r_right;
    assign left_valid  = r_left_valid;
    assign right_valid = r_right_valid;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a Philips (MODE=0) and a left-justified (MODE=1) receiver
// see the same slot stream. Slots are described as (channel, length, bits);
// the expected word of each finished slot is computed from the slot's bits
// and pushed when the boundary that finishes it is driven. A negedge monitor
// pops and compares whenever a valid strobe appears.
module tb_i2s_rx;
    localparam int DW = 24;
    localparam int SW = 32;
    localparam int W  = DW + 2;   // {slot_err, channel, word}

    logic BCLK = 1'b0;
    logic RST = 1'b0;
    logic LRCLK = 1'b0;
    logic LRCLK_LJ = 1'b0;
    logic ADCDAT = 1'b0;
    logic [DW-1:0] left0, right0, left1, right1;
    logic lv0, rv0, lv1, rv1;
    logic err0, err1;

    i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MODE(0)) u_i2s (
        .BCLK(BCLK), .RST(RST), .LRCLK(LRCLK), .ADCDAT(ADCDAT),
        .left(left0), .right(right0), .left_valid(lv0), .right_valid(rv0)
`ifdef I2S_RX_SLOT_CHECK_EN
        , .slot_err(err0)
`endif
    );

    i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MODE(1)) u_lj (
        .BCLK(BCLK), .RST(RST), .LRCLK(LRCLK_LJ), .ADCDAT(ADCDAT),
        .left(left1), .right(right1), .left_valid(lv1), .right_valid(rv1)
`ifdef I2S_RX_SLOT_CHECK_EN
        , .slot_err(err1)
`endif
    );

`ifndef I2S_RX_SLOT_CHECK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // ---------------- clock / cycle counter ----------------
    always #5 BCLK = ~BCLK;

    int edge_cnt = 0;
    always @(posedge BCLK) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int cyc_q0[$];
    int cyc_q1[$];
    logic [DW-1:0] mdl_l[2];
    logic [DW-1:0] mdl_r[2];
    bit started = 0;

    // ---------------- slot stream description ----------------
    bit          ws_s[$];
    bit          d_s[$];
    int          start_s[$];
    bit          sch[$];
    int          slen[$];
    logic [63:0] sdat[$];
    bit          nxt_ch = 0;
    int          reset_edge = -1;
    int          lens_tab[10] = '{32, 32, 32, 16, 31, 33, 64, 20, 24, 25};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Append one slot; channels alternate automatically.
    task automatic add_slot(input int len, input logic [63:0] dat);
        sch.push_back(nxt_ch);
        slen.push_back(len);
        sdat.push_back(dat);
        for (int j = 0; j < len; j++) begin
            ws_s.push_back(nxt_ch);
            d_s.push_back(dat[63-j]);
            start_s.push_back(j == 0 ? sch.size() - 1 : -1);
        end
        nxt_ch = !nxt_ch;
    endtask

    // Reference: the first min(len, DW) slot bits, left-aligned in DW bits.
    function automatic logic [W-1:0] expect_of(input int s);
        int n;
        logic [63:0] t;
        logic err;
        n   = (slen[s] < DW) ? slen[s] : DW;
        t   = sdat[s] >> (64 - n);
        t   = t << (DW - n);
        err = (slen[s] != SW);
        return {err, sch[s], t[DW-1:0]};
    endfunction

    // ---------------- monitor ----------------
    task automatic mon(input int inst, input logic lv, input logic rv,
                       input logic [DW-1:0] l, input logic [DW-1:0] r, input logic e);
        logic [W-1:0] ex;
        int cyc;
        chk("both_valid", {63'd0, lv & rv}, 64'd0);
        if (lv | rv) begin
            if ((inst == 0 && exp_q0.size() == 0) || (inst == 1 && exp_q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid inst=%0d actual=%0b%0b required=none", inst, lv, rv);
            end else begin
                if (inst == 0) begin
                    ex = exp_q0.pop_front(); cyc = cyc_q0.pop_front();
                end else begin
                    ex = exp_q1.pop_front(); cyc = cyc_q1.pop_front();
                end
                chk("valid_cycle", 64'(edge_cnt), 64'(cyc));
                chk("channel", {63'd0, rv}, {63'd0, ex[DW]});
                if (ex[DW]) mdl_r[inst] = ex[DW-1:0];
                else        mdl_l[inst] = ex[DW-1:0];
`ifdef I2S_RX_SLOT_CHECK_EN
                chk("slot_err", {63'd0, e}, {63'd0, ex[DW+1]});
`endif
            end
        end else begin
`ifdef I2S_RX_SLOT_CHECK_EN
            chk("slot_err_idle", {63'd0, e}, 64'd0);
`endif
        end
        chk(inst == 0 ? "left_i2s" : "left_lj", 64'(l), 64'(mdl_l[inst]));
        chk(inst == 0 ? "right_i2s" : "right_lj", 64'(r), 64'(mdl_r[inst]));
    endtask

    always @(negedge BCLK) begin
        if (started && !RST) begin
            mon(0, lv0, rv0, left0, right0, err0);
            mon(1, lv1, rv1, left1, right1, err1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit prev_ws;
        bit armed;
        int n;
        int s;

        for (int i = 0; i < 2; i++) begin
            mdl_l[i] = '0;
            mdl_r[i] = '0;
        end

        // Reset state
        #1 RST = 1'b1;
        #2;
        chk("rst_left", 64'(left0), 64'd0);
        chk("rst_right", 64'(right0), 64'd0);
        chk("rst_lvalid", {63'd0, lv0}, 64'd0);
        chk("rst_rvalid", {63'd0, rv0}, 64'd0);
        chk("rst_left_lj", 64'(left1), 64'd0);
        chk("rst_slot_err", {63'd0, err0}, 64'd0);
        repeat (2) @(negedge BCLK);
        RST = 1'b0;
        started = 1;
        repeat (2) @(negedge BCLK);

        // Directed slots, then random ones, a mid-slot reset, and a closing slot.
        add_slot(12, {$urandom(), $urandom()});            // partial left, discarded
        add_slot(32, {$urandom(), $urandom()});            // right
        add_slot(32, {32'h12345600, 32'h0});               // left 0x123456
        add_slot(32, {32'hABCDEF00, 32'h0});               // right 0xABCDEF
        add_slot(16, {16'h8001, 48'h0});                   // short left -> 0x800100
        add_slot(64, {16'h7FFF, 16'h0000, $urandom()});    // long right -> 0x7FFF00
        add_slot(32, {$urandom(), $urandom()});
        add_slot(31, {$urandom(), $urandom()});
        add_slot(33, {$urandom(), $urandom()});
        for (int i = 0; i < 24; i++) begin
            add_slot(lens_tab[$urandom_range(0, 9)], {$urandom(), $urandom()});
        end
        if (nxt_ch) add_slot(32, {$urandom(), $urandom()});
        reset_edge = ws_s.size() + 9;                      // bit 10 of a left slot
        add_slot(32, {$urandom(), $urandom()});
        for (int i = 0; i < 8; i++) begin
            add_slot(lens_tab[$urandom_range(0, 9)], {$urandom(), $urandom()});
        end
        add_slot(3, 64'h0);                                // closes the last real slot

        prev_ws = 0;
        armed   = 0;
        n       = ws_s.size();
        for (int i = 0; i < n; i++) begin
            @(negedge BCLK);
            if (i == reset_edge) begin
                #1 RST = 1'b1;
                #1;
                chk("midrst_left", 64'(left0), 64'd0);
                chk("midrst_right", 64'(right0), 64'd0);
                chk("midrst_left_lj", 64'(left1), 64'd0);
                chk("midrst_right_lj", 64'(right1), 64'd0);
                for (int k = 0; k < 2; k++) begin
                    mdl_l[k] = '0;
                    mdl_r[k] = '0;
                end
                prev_ws = 0;
                armed   = 0;
                #1 RST = 1'b0;
            end
            LRCLK    = (i + 1 < n) ? ws_s[i+1] : ws_s[i];
            LRCLK_LJ = ws_s[i];
            ADCDAT   = d_s[i];
            s = start_s[i];
            if (s >= 0 && ws_s[i] != prev_ws) begin
                if (armed && s > 0) begin
                    exp_q0.push_back(expect_of(s - 1));
                    exp_q1.push_back(expect_of(s - 1));
                    cyc_q0.push_back(edge_cnt + 1);
                    cyc_q1.push_back(edge_cnt + 1);
                end
                armed   = 1;
                prev_ws = ws_s[i];
            end
        end

        // Bounded drain: anything still queued was never presented.
        repeat (4) @(negedge BCLK);
        chk("pending_i2s", 64'(exp_q0.size()), 64'd0);
        chk("pending_lj", 64'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
